data_sram_resp: RTL

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp_pkg.sv | 26 ++
 rtl/data_sram_resp_ram.sv | 30 +++
 rtl/data_sram_resp.sv | 90 +++++++++
 3 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared constants and helpers for the data-port SRAM/MMIO responder.
// Optional TIMER register is built only when DATA_SRAM_RESP_TIMER_EN is defined.
package data_sram_resp_pkg;

  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hBFAF_0000;

  localparam logic [15:0] MMIO_OFF_LED     = 16'h0000;
  localparam logic [15:0] MMIO_OFF_SCRATCH = 16'h0004;
  localparam logic [15:0] MMIO_OFF_TIMER   = 16'h0008;
  localparam logic [15:0] MMIO_OFF_ID      = 16'h000C;

  localparam logic [31:0] MMIO_ID_VALUE = 32'h4D43_5055;

  // Byte-lane merge: lanes with be[i]=1 take new_w, others keep old_w.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_resp_ram.sv
// Word array with byte-lane writes and a registered, read-first read port.
module data_sram_resp_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Array write: per-lane update, no reset so it maps onto block RAM.
  // NOTE: memories are never reset; contents must survive a mid-run reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Registered read every cycle; sees pre-write contents (read-first).
  // NOTE: non-blocking assignment is what makes the read return the old word.
  always_ff @(posedge clk) begin
    if (!resetn) rdata <= '0;
    else         rdata <= mem[addr];
  end

endmodule

// File: rtl/data_sram_resp.sv
// CPU data-port responder: internal RAM plus a 64 KiB MMIO window
// (LED, SCRATCH, optional TIMER, ID). Fixed one-cycle read latency.
// Define DATA_SRAM_RESP_TIMER_EN to build the free-running TIMER at offset 0x8.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [15:0] led
);

  logic        is_mmio;
  logic [15:0] mmio_off;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] mmio_rd;
  logic [31:0] mmio_rdata_q;
  logic        is_mmio_q;
  logic [31:0] led_w;
  logic [31:0] scratch_q;

  assign is_mmio  = (addr[31:16] == MMIO_BASE[31:16]);
  assign mmio_off = addr[15:0];
  // RAM writes are blocked during reset and for MMIO addresses.
  assign ram_we   = (resetn && !is_mmio) ? we : 4'b0000;

  data_sram_resp_ram #(.AW(RAM_AW)) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .addr   (addr[RAM_AW+1:2]),
    .we     (ram_we),
    .wdata  (din),
    .rdata  (ram_rdata)
  );

`ifdef DATA_SRAM_RESP_TIMER_EN
  logic [31:0] timer_q;

  // Free-running counter; written lanes override the incremented value.
  always_ff @(posedge clk) begin
    if (!resetn) timer_q <= '0;
    else         timer_q <= merge_lanes(timer_q + 32'd1, din,
                                        (is_mmio && mmio_off == MMIO_OFF_TIMER) ? we : 4'b0000);
  end
`endif

  // MMIO read mux, using register values before this edge's update.
  // NOTE: default assignment first so no path leaves mmio_rd unassigned (no latch).
  always_comb begin
    mmio_rd = '0;
    case (mmio_off)
      MMIO_OFF_LED:     mmio_rd = {16'h0000, led};
      MMIO_OFF_SCRATCH: mmio_rd = scratch_q;
`ifdef DATA_SRAM_RESP_TIMER_EN
      MMIO_OFF_TIMER:   mmio_rd = timer_q;
`endif
      MMIO_OFF_ID:      mmio_rd = MMIO_ID_VALUE;
      default:          mmio_rd = '0;
    endcase
  end

  assign led_w = merge_lanes({16'h0000, led}, din, {2'b00, we[1:0]});

  // MMIO register writes and the registered read-path select.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led          <= '0;
      scratch_q    <= '0;
      mmio_rdata_q <= '0;
      is_mmio_q    <= 1'b0;
    end else begin
      is_mmio_q    <= is_mmio;
      mmio_rdata_q <= mmio_rd;
      if (is_mmio && mmio_off == MMIO_OFF_LED)
        led <= led_w[15:0];
      if (is_mmio && mmio_off == MMIO_OFF_SCRATCH)
        scratch_q <= merge_lanes(scratch_q, din, we);
    end
  end

  assign dout = is_mmio_q ? mmio_rdata_q : ram_rdata;

endmodule
